// File: rtl/avl_burst_mem_tester.sv
// avl_burst_mem_tester: Avalon-MM burst write/readback pattern tester for a DDR3 local port.
//   iCLK, iRST_n          clock, asynchronous active-low reset
//   iSTART ... iSTOP_ON_ERR  test configuration, latched on an accepted start pulse
//   local_init_done       start is accepted only once calibration is done
//   avl_*                 Avalon-MM burst master towards the memory controller
//   oBUSY/oPASS/oFAIL/oCFG_ERR/oERR_COUNT/oFAIL_ADDR/oSTATE  test status and debug
module avl_burst_mem_tester #(
  parameter int ADDR_W  = 26,
  parameter int DATA_W  = 128,
  parameter int BURST_W = 4,
  parameter int ERR_W   = 16
) (
  input  logic               iCLK,
  input  logic               iRST_n,
  input  logic               iSTART,
  input  logic [1:0]         iMODE,
  input  logic [ADDR_W-1:0]  iBASE_ADDR,
  input  logic [ADDR_W-1:0]  iLAST_ADDR,
  input  logic [BURST_W-1:0] iBURST_LEN,
  input  logic               iSTOP_ON_ERR,
  input  logic               local_init_done,
  input  logic               avl_waitrequest_n,
  output logic [ADDR_W-1:0]  avl_address,
  output logic [BURST_W-1:0] avl_size,
  output logic               avl_burstbegin,
  output logic               avl_write,
  output logic [DATA_W-1:0]  avl_writedata,
  output logic               avl_read,
  input  logic               avl_readdatavalid,
  input  logic [DATA_W-1:0]  avl_readdata,
  output logic               oBUSY,
  output logic               oPASS,
  output logic               oFAIL,
  output logic               oCFG_ERR,
  output logic [ERR_W-1:0]   oERR_COUNT,
  output logic [ADDR_W-1:0]  oFAIL_ADDR,
  output logic [3:0]         oSTATE
);
  typedef enum logic [3:0] {IDLE, WR, WR_NEXT, RD_CMD, RD_DATA, RD_NEXT, PASS, FAIL} state_t;
  localparam int LANES = DATA_W / 32;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic [1:0] m,
                                                input logic [31:0] s);
    logic [31:0] a32;
    logic [31:0] h;
    logic [DATA_W-1:0] p;
    a32 = 32'(a);
    h = a32 + s;
    p = '0;
    for (int i = 0; i < LANES; i++)
      p[i*32 +: 32] = m == 2'd3 ? h ^ {h[15:0], h[31:16]} ^ (32'(i) * 32'h9E3779B9) : a32;
    return m == 2'd1 ? ~p : m == 2'd2 ? ONE << (a32 % 32'(DATA_W)) : p;
  endfunction

  state_t state_q, state_d;
  logic [31:0] cnt_q, seed_q, seed_d;
  logic [1:0] mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d, last_q, last_d, cur_q, cur_d, fail_addr_q, fail_addr_d;
  logic [BURST_W-1:0] len_q, len_d, beat_q, beat_d, n;
  logic stop_q, stop_d, cfg_err_q, cfg_err_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [ADDR_W:0] rem, len_x;
  logic [ADDR_W-1:0] beat_addr;
  logic start, last_beat, at_end, mismatch;

  // Remaining-window arithmetic is one bit wider so a window ending at all-ones cannot wrap.
  assign len_x     = (ADDR_W+1)'(len_q == '0 ? BURST_W'(1) : len_q);
  assign rem       = {1'b0, last_q} - {1'b0, cur_q} + 1'b1;
  assign n         = rem < len_x ? rem[BURST_W-1:0] : len_x[BURST_W-1:0];
  assign at_end    = {1'b0, cur_q} + (ADDR_W+1)'(n) > {1'b0, last_q};
  assign beat_addr = cur_q + ADDR_W'(beat_q);
  assign last_beat = beat_q == n - 1'b1;
  assign mismatch  = avl_readdata != pattern(beat_addr, mode_q, seed_q);
  assign start     = (state_q == IDLE || state_q == PASS || state_q == FAIL) && iSTART && local_init_done;

  assign oBUSY      = !(state_q == IDLE || state_q == PASS || state_q == FAIL);
  assign oPASS      = state_q == PASS;
  assign oFAIL      = state_q == FAIL;
  assign oCFG_ERR   = cfg_err_q;
  assign oERR_COUNT = err_q;
  assign oFAIL_ADDR = fail_addr_q;
  assign oSTATE     = state_q;

  always_comb begin
    state_d = state_q;
    seed_d = seed_q;
    mode_d = mode_q;
    base_d = base_q;
    last_d = last_q;
    len_d = len_q;
    stop_d = stop_q;
    cur_d = cur_q;
    beat_d = beat_q;
    err_d = err_q;
    fail_addr_d = fail_addr_q;
    cfg_err_d = cfg_err_q;
    avl_address = '0;
    avl_size = '0;
    avl_burstbegin = 1'b0;
    avl_write = 1'b0;
    avl_read = 1'b0;
    avl_writedata = '0;
    case (state_q)
      IDLE, PASS, FAIL: if (start) begin
        seed_d = cnt_q;
        mode_d = iMODE;
        base_d = iBASE_ADDR;
        last_d = iLAST_ADDR;
        len_d = iBURST_LEN;
        stop_d = iSTOP_ON_ERR;
        cur_d = iBASE_ADDR;
        beat_d = '0;
        err_d = '0;
        fail_addr_d = '0;
        cfg_err_d = iBASE_ADDR > iLAST_ADDR;
        state_d = iBASE_ADDR > iLAST_ADDR ? FAIL : WR;
      end
      WR: begin
        avl_write = 1'b1;
        avl_address = cur_q;
        avl_size = n;
        avl_burstbegin = beat_q == '0;
        avl_writedata = pattern(beat_addr, mode_q, seed_q);
        if (avl_waitrequest_n) begin
          beat_d = last_beat ? '0 : beat_q + 1'b1;
          state_d = last_beat ? WR_NEXT : WR;
        end
      end
      WR_NEXT: begin
        cur_d = at_end ? base_q : cur_q + ADDR_W'(n);
        state_d = at_end ? RD_CMD : WR;
      end
      RD_CMD: begin
        avl_read = 1'b1;
        avl_burstbegin = 1'b1;
        avl_address = cur_q;
        avl_size = n;
        beat_d = '0;
        state_d = avl_waitrequest_n ? RD_DATA : RD_CMD;
      end
      RD_DATA: if (avl_readdatavalid) begin
        if (mismatch) begin
          err_d = &err_q ? err_q : err_q + 1'b1;
          fail_addr_d = err_q == '0 ? beat_addr : fail_addr_q;
        end
        beat_d = last_beat ? '0 : beat_q + 1'b1;
        state_d = last_beat ? RD_NEXT : RD_DATA;
      end
      RD_NEXT: begin
        if (err_q != '0 && stop_q) state_d = FAIL;
        else if (at_end) state_d = err_q == '0 ? PASS : FAIL;
        else begin
          cur_d = cur_q + ADDR_W'(n);
          state_d = RD_CMD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n)
    if (!iRST_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      seed_q <= '0;
      mode_q <= '0;
      base_q <= '0;
      last_q <= '0;
      len_q <= '0;
      stop_q <= 1'b0;
      cur_q <= '0;
      beat_q <= '0;
      err_q <= '0;
      fail_addr_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_q + 1'b1;
      seed_q <= seed_d;
      mode_q <= mode_d;
      base_q <= base_d;
      last_q <= last_d;
      len_q <= len_d;
      stop_q <= stop_d;
      cur_q <= cur_d;
      beat_q <= beat_d;
      err_q <= err_d;
      fail_addr_q <= fail_addr_d;
      cfg_err_q <= cfg_err_d;
    end
endmodule

// File: tb/tb_avl_burst_mem_tester.sv
// tb_avl_burst_mem_tester: directed bench with a small Avalon burst slave model.
module tb_avl_burst_mem_tester;
  localparam int AW = 26, DW = 128, BW = 4, EW = 16;
  localparam logic [AW-1:0] ONES = '1;

  logic iCLK = 1'b0, iRST_n = 1'b0, iSTART = 1'b0, iSTOP_ON_ERR = 1'b0, local_init_done = 1'b1;
  logic [1:0] iMODE = '0;
  logic [AW-1:0] iBASE_ADDR = '0, iLAST_ADDR = '0;
  logic [BW-1:0] iBURST_LEN = '0;
  logic avl_waitrequest_n = 1'b1, avl_readdatavalid = 1'b0;
  logic [DW-1:0] avl_readdata = '0;
  logic [AW-1:0] avl_address, oFAIL_ADDR;
  logic [BW-1:0] avl_size;
  logic avl_burstbegin, avl_write, avl_read, oBUSY, oPASS, oFAIL, oCFG_ERR;
  logic [DW-1:0] avl_writedata;
  logic [EW-1:0] oERR_COUNT;
  logic [3:0] oSTATE;

  always #5 iCLK = ~iCLK;

  avl_burst_mem_tester dut (
    .iCLK(iCLK), .iRST_n(iRST_n), .iSTART(iSTART), .iMODE(iMODE), .iBASE_ADDR(iBASE_ADDR),
    .iLAST_ADDR(iLAST_ADDR), .iBURST_LEN(iBURST_LEN), .iSTOP_ON_ERR(iSTOP_ON_ERR),
    .local_init_done(local_init_done), .avl_waitrequest_n(avl_waitrequest_n),
    .avl_address(avl_address), .avl_size(avl_size), .avl_burstbegin(avl_burstbegin),
    .avl_write(avl_write), .avl_writedata(avl_writedata), .avl_read(avl_read),
    .avl_readdatavalid(avl_readdatavalid), .avl_readdata(avl_readdata), .oBUSY(oBUSY),
    .oPASS(oPASS), .oFAIL(oFAIL), .oCFG_ERR(oCFG_ERR), .oERR_COUNT(oERR_COUNT),
    .oFAIL_ADDR(oFAIL_ADDR), .oSTATE(oSTATE)
  );

  logic [DW-1:0] mem [64];
  logic rnd_wait = 1'b0, corrupt_en = 1'b0, mon_clr = 1'b0;
  logic [AW-1:0] corrupt_addr = '0;
  logic [AW-1:0] wptr = '0, waddr, rd_ptr = '0, rd_max = '0, wr_first = '0, wr_lastw = '0, p_addr = '0;
  logic [DW-1:0] p_data = '0;
  logic p_bb = 1'b0, prev_stall = 1'b0;
  logic [BW-1:0] p_size = '0, rd_left = '0;
  logic [BW-1:0] wr_size [4];
  logic [1:0] rd_dly = '0;
  int wr_bursts = 0, rd_cmds = 0, act_cycles = 0, viol = 0, both = 0;
  int n_cmp = 0, n_err = 0;

  assign waddr = avl_burstbegin ? avl_address : wptr;

  always @(posedge iCLK) begin
    avl_waitrequest_n <= rnd_wait ? 1'($urandom_range(0, 1)) : 1'b1;
    avl_readdatavalid <= 1'b0;
    if (avl_write && avl_read) both <= both + 1;
    if (avl_write || avl_read) act_cycles <= act_cycles + 1;
    if (prev_stall && (!avl_write || avl_address != p_addr || avl_writedata != p_data ||
                       avl_burstbegin != p_bb || avl_size != p_size)) viol <= viol + 1;
    prev_stall <= avl_write && !avl_waitrequest_n;
    p_addr <= avl_address;
    p_data <= avl_writedata;
    p_bb <= avl_burstbegin;
    p_size <= avl_size;
    if (avl_write && avl_waitrequest_n) begin
      mem[waddr[5:0]] <= avl_writedata;
      wptr <= waddr + 1'b1;
      wr_lastw <= waddr;
      if (avl_burstbegin) begin
        if (wr_bursts == 0) wr_first <= avl_address;
        if (wr_bursts < 4) wr_size[wr_bursts[1:0]] <= avl_size;
        wr_bursts <= wr_bursts + 1;
      end
    end
    if (rd_left != '0) begin
      if (rd_dly != '0) rd_dly <= rd_dly - 1'b1;
      else begin
        avl_readdatavalid <= 1'b1;
        avl_readdata <= mem[rd_ptr[5:0]] ^ ((corrupt_en && rd_ptr == corrupt_addr) ? DW'(1) : DW'(0));
        rd_ptr <= rd_ptr + 1'b1;
        rd_left <= rd_left - 1'b1;
      end
    end
    if (avl_read && avl_waitrequest_n) begin
      rd_left <= avl_size;
      rd_ptr <= avl_address;
      rd_dly <= 2'd1;
      rd_cmds <= rd_cmds + 1;
      rd_max <= avl_address + AW'(avl_size) - 1'b1;
    end
    if (!iRST_n) rd_left <= '0;
    if (mon_clr) begin
      wr_bursts <= 0;
      rd_cmds <= 0;
      act_cycles <= 0;
      viol <= 0;
      both <= 0;
      rd_max <= '0;
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [AW-1:0] b, input logic [AW-1:0] l, input logic [BW-1:0] len,
                     input logic [1:0] m, input logic stop);
    iBASE_ADDR = b;
    iLAST_ADDR = l;
    iBURST_LEN = len;
    iMODE = m;
    iSTOP_ON_ERR = stop;
  endtask

  task automatic go();
    @(negedge iCLK);
    iSTART = 1'b1;
    mon_clr = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    while (!(oPASS || oFAIL) && i < lim) begin
      @(negedge iCLK);
      i++;
    end
    check("done_in_time", DW'(i < lim), DW'(1));
  endtask

  initial begin
    repeat (3) @(negedge iCLK);
    check("rst_state", DW'(oSTATE), DW'(0));
    check("rst_flags", DW'({oBUSY, oPASS, oFAIL, oCFG_ERR}), DW'(0));
    check("rst_bus", DW'({avl_write, avl_read, avl_burstbegin}), DW'(0));
    check("rst_err", DW'({oERR_COUNT, oFAIL_ADDR}), DW'(0));
    iRST_n = 1'b1;

    cfg(0, 15, 4, 2'd0, 1'b0);
    go();
    check("t1_busy", DW'(oBUSY), DW'(1));
    wait_done(2000);
    check("t1_pass", DW'({oPASS, oFAIL, oBUSY}), DW'(3'b100));
    check("t1_errcnt", DW'(oERR_COUNT), DW'(0));
    check("t1_wr_bursts", DW'(wr_bursts), DW'(4));
    check("t1_rd_cmds", DW'(rd_cmds), DW'(4));
    check("t1_sizes", DW'({wr_size[0], wr_size[1], wr_size[2], wr_size[3]}), DW'(16'h4444));
    check("t1_word5", mem[5], {4{32'h5}});
    check("t1_no_overlap", DW'(both), DW'(0));

    cfg(0, 7, 3, 2'd1, 1'b0);
    go();
    wait_done(2000);
    check("m1_pass", DW'(oPASS), DW'(1));
    check("m1_sizes", DW'({wr_size[0], wr_size[1], wr_size[2]}), DW'(12'h332));
    check("m1_word2", mem[2], ~{4{32'h2}});

    corrupt_en = 1'b1;
    corrupt_addr = 9;
    cfg(0, 15, 4, 2'd0, 1'b1);
    go();
    wait_done(2000);
    corrupt_en = 1'b0;
    check("t2_fail", DW'({oPASS, oFAIL}), DW'(2'b01));
    check("t2_errcnt", DW'(oERR_COUNT), DW'(1));
    check("t2_fail_addr", DW'(oFAIL_ADDR), DW'(9));
    check("t2_rd_cmds", DW'(rd_cmds), DW'(3));
    check("t2_rd_max", DW'(rd_max), DW'(11));

    rnd_wait = 1'b1;
    cfg(3, 12, 4, 2'd2, 1'b0);
    go();
    local_init_done = 1'b0;
    wait_done(4000);
    local_init_done = 1'b1;
    rnd_wait = 1'b0;
    check("t3_pass", DW'(oPASS), DW'(1));
    check("t3_wr_bursts", DW'(wr_bursts), DW'(3));
    check("t3_sizes", DW'({wr_size[0], wr_size[1], wr_size[2]}), DW'(12'h442));
    check("t3_word7", mem[7], DW'(1) << 7);
    check("t3_word3", mem[3], DW'(1) << 3);
    check("t3_stable", DW'(viol), DW'(0));
    check("t3_rd_cmds", DW'(rd_cmds), DW'(3));

    cfg(10, 5, 4, 2'd0, 1'b0);
    go();
    wait_done(100);
    repeat (3) @(negedge iCLK);
    check("t4_flags", DW'({oPASS, oFAIL, oCFG_ERR, oBUSY}), DW'(4'b0110));
    check("t4_no_traffic", DW'(act_cycles), DW'(0));

    cfg(ONES - 2, ONES, 8, 2'd0, 1'b0);
    go();
    wait_done(2000);
    check("t5_pass", DW'({oPASS, oCFG_ERR}), DW'(2'b10));
    check("t5_one_burst", DW'({wr_bursts[7:0], rd_cmds[7:0]}), DW'(16'h0101));
    check("t5_size", DW'(wr_size[0]), DW'(3));
    check("t5_first", DW'(wr_first), DW'(ONES - 2));
    check("t5_lastw", DW'(wr_lastw), DW'(ONES));
    check("t5_rd_max", DW'(rd_max), DW'(ONES));

    cfg(20, 40, 5, 2'd3, 1'b0);
    go();
    wait_done(2000);
    check("m3_pass", DW'({oPASS, oERR_COUNT}), DW'({1'b1, 16'h0}));
    check("m3_wr_bursts", DW'(wr_bursts), DW'(5));

    cfg(0, 15, 4, 2'd0, 1'b0);
    go();
    repeat (2) @(negedge iCLK);
    check("t6_mid_write", DW'(avl_write), DW'(1));
    #2 iRST_n = 1'b0;
    #1;
    check("t6_rst_bus", DW'({avl_write, avl_read, avl_burstbegin, avl_address}), DW'(0));
    check("t6_rst_state", DW'({oSTATE, oBUSY, oPASS, oFAIL}), DW'(0));
    @(negedge iCLK);
    iRST_n = 1'b1;
    local_init_done = 1'b0;
    go();
    repeat (5) @(negedge iCLK);
    check("t6_ignored", DW'({oSTATE, oBUSY}), DW'(0));
    check("t6_no_traffic", DW'(act_cycles), DW'(0));
    local_init_done = 1'b1;
    go();
    check("t6_busy", DW'(oBUSY), DW'(1));
    wait_done(2000);
    check("t6_pass", DW'(oPASS), DW'(1));
    check("t6_word5", mem[5], {4{32'h5}});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avl_burst_mem_tester.md
Name: avl_burst_mem_tester

Overview:
- Parametrised Avalon-MM DDR3 memory tester.
- Writes a selectable data pattern over a programmable address window in bursts, reads the window back in bursts, and compares every beat against regenerated expected data.
- Reports pass/fail, a saturating error count and the first failing address.
- Sits between the DDR3 controller's Avalon local port and board status LEDs/debug logic. Replaces the single-beat, fixed-pattern, full-range test.

Parameters:
ADDR_W, 26, Avalon word-address width
DATA_W, 128, Avalon data width; multiple of 32
BURST_W, 4, width of avl_size; maximum burst = 2^BURST_W-1 beats
ERR_W, 16, error counter width

Ports:
iCLK  in  1  system clock
iRST_n  in  1  asynchronous active-low reset
iSTART  in  1  single-cycle start pulse
iMODE  in  2  pattern: 0 address, 1 inverted address, 2 walking one, 3 seeded hash
iBASE_ADDR  in  ADDR_W  first word of test window
iLAST_ADDR  in  ADDR_W  last word of test window (inclusive)
iBURST_LEN  in  BURST_W  beats per burst; 0 is treated as 1
iSTOP_ON_ERR  in  1  1: finish at first mismatching burst
local_init_done  in  1  controller calibration complete
avl_waitrequest_n  in  1  slave ready
avl_address  out  ADDR_W  burst start address
avl_size  out  BURST_W  burst length
avl_burstbegin  out  1  first beat of a write burst / read command
avl_write  out  1  write request
avl_writedata  out  DATA_W  write beat data
avl_read  out  1  read request
avl_readdatavalid  in  1  read beat valid
avl_readdata  in  DATA_W  read beat data
oBUSY  out  1  test in progress
oPASS  out  1  finished, no errors
oFAIL  out  1  finished with errors or bad config
oCFG_ERR  out  1  iBASE_ADDR > iLAST_ADDR at start
oERR_COUNT  out  ERR_W  mismatching beats, saturating
oFAIL_ADDR  out  ADDR_W  word address of first mismatch
oSTATE  out  4  state encoding for debug

Behaviour:
- Reset (async, any time including mid-burst): all outputs 0, state IDLE, counters 0, seed 0. Outstanding reads after reset are ignored.
- Free-running 32-bit counter cnt. Config inputs and seed<=cnt are latched on an accepted start.
- iSTART is accepted only in IDLE/PASS/FAIL and only when local_init_done=1; otherwise it is ignored.
- Accepted start clears oPASS, oFAIL, oCFG_ERR, oERR_COUNT and oFAIL_ADDR, and sets oBUSY the next cycle.
- base>last: go to FAIL with oCFG_ERR=1. No bus traffic.
- Pattern for word a, where k = a mod DATA_W and s = seed:
  - mode 0: {DATA_W/32{a zero-extended to 32}}
  - mode 1: bitwise inverse of mode 0
  - mode 2: only bit k set
  - mode 3: each 32-bit lane i = (a+s) ^ {(a+s) rotated by 16} ^ (i*32'h9E3779B9)
- Burst size per burst: n = min(len, last-cur+1). Compute in ADDR_W+1 bits so last = all-ones does not wrap.
- States:
  - IDLE: wait for start.
  - WR: avl_write=1, avl_address=cur, avl_size=n. avl_burstbegin=1 on beat 0 only. Writedata = pattern(cur+beat). Beat advances only when avl_waitrequest_n=1. After beat n-1 is accepted, go to WR_NEXT.
  - WR_NEXT: avl_write=0 for one cycle. If cur+n > last, set cur=base and go to RD_CMD; else cur+=n and go to WR.
  - RD_CMD: avl_read=1, avl_burstbegin=1, avl_size=n, held until avl_waitrequest_n=1, then go to RD_DATA.
  - RD_DATA: on each avl_readdatavalid, compare against pattern(cur+beat).
    - On mismatch: oERR_COUNT++ (saturate at all-ones). If first error, oFAIL_ADDR=cur+beat.
    - After n beats, go to RD_NEXT. readdatavalid in any other state is ignored.
  - RD_NEXT:
    - If errors and iSTOP_ON_ERR, go to FAIL.
    - Else if cur+n > last, go to PASS when err=0, otherwise FAIL.
    - Else cur+=n and go to RD_CMD.
  - PASS/FAIL: sticky. oBUSY=0 and the respective flag is 1 until the next accepted start.
- avl_write and avl_read are never both 1. Each is deasserted at least one cycle between bursts.
- local_init_done falling mid-test: no effect. The test completes.

Test Plan:
- base=0, last=15, len=4, mode 0, ideal slave (waitrequest_n=1, 2-cycle read latency) -> 4 write bursts + 4 read bursts of size 4; word 5 = {4{32'h5}}; oPASS=1, oERR_COUNT=0.
- Same with slave corrupting word 9 bit 0, iSTOP_ON_ERR=1 -> oFAIL=1, oERR_COUNT=1, oFAIL_ADDR=9, no read of words 12..15.
- base=3, last=12, len=4, mode 2, random waitrequest_n -> sizes 4,4,2; each beat held stable while stalled; word 7 = bit 7 set; pass.
- base=10, last=5 -> oFAIL=1, oCFG_ERR=1, no avl_write/avl_read.
- last=all-ones, base=all-ones-2, len=8 -> single burst size 3, no address wrap, pass.
- Reset asserted mid-write burst, then start pulse with local_init_done=0 -> outputs 0 and stay IDLE; start with local_init_done=1 -> test runs.
